// File: rtl/uart_pkg.sv
// Shared types and helpers for the 9-bit UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 9;

  // Clock cycles per oversampling tick, truncated toward zero.
  function automatic int uart_div(input int clk_hz, input int baud, input int rate);
    return clk_hz / (baud * rate);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick divider: counts 0..DIV-1 and pulses tick on DIV-1.
// restart forces the count back to 0 so sampling aligns to a start edge.
module uart_rx_tick_gen #(
  parameter int DIV = 162
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on restart or wrap, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 9-bit UART receiver: 1 start, 9 data (LSB first), 1 stop, no parity.
// Optional 2-of-3 majority sampling is enabled by UART_RX_MAJORITY_VOTE_EN.
// Output handshake: data_valid and framing_error are single-cycle pulses with
// no ready/backpressure; the consumer must take data before the next frame ends.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD_RATE, SAMPLE_RATE);
  localparam int SW  = $clog2(SAMPLE_RATE);
  localparam logic [SW-1:0] S_MID  = SW'(SAMPLE_RATE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_RATE - 1);
  localparam logic [3:0]    B_LAST = 4'(UART_DATA_BITS - 1);

  uart_rx_state_t state_q, state_d;

  logic                      rx_meta_q, rx_s_q, rx_prev_q;
  logic [SW-1:0]             sample_cnt_q, sample_cnt_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      restart;
  logic                      tick;
  logic                      bit_s;
  logic                      fall_edge;
  logic [SW-1:0]             sample_inc;

  uart_rx_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Keep rx_s from the two most recent ticks; [1] is the older sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else if (tick) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign bit_s = rx_s_q;
`endif

  assign sample_inc = (sample_cnt_q == S_LAST) ? '0 : sample_cnt_q + 1'b1;

  // Next-state logic: frame sequencing, counters, shift register and output pulses.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
    restart      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d      = START;
          restart      = 1'b1;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      end
      START: begin
        if (tick) begin
          sample_cnt_d = sample_inc;
          if (sample_cnt_q == S_MID) begin
            // A high line at mid-start was a glitch, not a frame.
            if (!bit_s) begin
              state_d      = DATA;
              sample_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_cnt_d = sample_inc;
          if (sample_cnt_q == S_LAST) begin
            shift_d   = {bit_s, shift_q[UART_DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == B_LAST) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          sample_cnt_d = sample_inc;
          if (sample_cnt_q == S_LAST) begin
            state_d = IDLE;
            if (bit_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Stimulus pushes {framing_error, data} expectations into
// exp_q; an independent monitor pops and compares on every output pulse.
// Define UART_RX_MAJORITY_VOTE_EN to add the mid-bit glitch frame.
module tb_uart_rx;

  // 1_600_000 / (9600 * 16) = 10.41 -> 10 cycles per tick, 160 per bit.
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 9600;
  localparam int SR     = 16;
  localparam int DIV    = 10;
  localparam int BIT    = DIV * SR;
  // Start edge to output pulse: 10.5 bits plus sync/edge/register latency.
  localparam int LAT_LO = 1678;
  localparam int LAT_HI = 1690;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [8:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  logic [9:0] exp_q[$];
  logic [8:0] last_good;
  int         n_checks;
  int         n_fail;
  int         cyc;
  int         start_cyc;

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .SAMPLE_RATE(SR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  // Clock and cycle counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && (data_valid || framing_error)) begin
      check("valid_ferr_exclusive", 32'(data_valid & framing_error), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: valid=%0b ferr=%0b data=0x%0h, expected no output",
                 data_valid, framing_error, data);
      end else begin
        logic [9:0] e;
        int lat;
        e = exp_q.pop_front();
        lat = cyc - start_cyc;
        check("frame_result", 32'({framing_error, data}), 32'(e));
        check("busy_at_pulse", 32'(busy), 32'd0);
        check("latency_in_window", 32'((lat >= LAT_LO) && (lat <= LAT_HI)), 32'd1);
      end
    end
  end

  // Drive one bit period; optionally invert for one tick around mid-bit.
  task automatic drive_bit(input logic v, input bit mark, input bit glitch);
    for (int i = 0; i < BIT; i++) begin
      @(negedge clock);
      if (mark && i == 0) start_cyc = cyc;
      if (glitch && (i >= BIT/2 - 4) && (i < BIT/2 - 4 + DIV)) rx = ~v;
      else rx = v;
    end
  endtask

  // Send a frame. abort_bit < 9 asserts reset midway through that data bit.
  task automatic send_frame(input logic [8:0] d, input logic stop, input int abort_bit,
                            input int glitch_bit);
    if (abort_bit > 8) begin
      if (stop) begin
        exp_q.push_back({1'b0, d});
        last_good = d;
      end else begin
        exp_q.push_back({1'b1, last_good});
      end
    end
    drive_bit(1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 9; b++) begin
      if (b == abort_bit) begin
        for (int i = 0; i < BIT/2; i++) begin
          @(negedge clock);
          rx = d[b];
        end
        check("busy_mid_frame", 32'(busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        last_good = '0;
        return;
      end
      drive_bit(d[b], 1'b0, (b == glitch_bit));
    end
    drive_bit(stop, 1'b0, 1'b0);
    rx = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      rx = 1'b1;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    start_cyc = 0;
    last_good = '0;
    rx        = 1'b1;
    reset     = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;

    // 1: idle line after reset
    idle(2 * BIT);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_ferr", 32'(framing_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // 2: single good frame
    send_frame(9'h1A5, 1'b1, 99, -1);
    idle(BIT);

    // 3: false start of 4 ticks, then a good frame
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clock);
      rx = 1'b0;
    end
    idle(2 * BIT);
    check("false_start_idle", 32'(busy), 32'd0);
    check("false_start_data", 32'(data), 32'h1A5);
    send_frame(9'h0FF, 1'b1, 99, -1);
    idle(BIT);

    // 4: framing error, data must hold 0x0FF
    send_frame(9'h155, 1'b0, 99, -1);
    idle(2 * BIT);
    check("ferr_data_hold", 32'(data), 32'h0FF);

    // 5: back-to-back frames
    send_frame(9'h000, 1'b1, 99, -1);
    send_frame(9'h1FF, 1'b1, 99, -1);
    idle(BIT);

    // 6: reset mid-frame at bit 4, then a clean frame
    send_frame(9'h1A5, 1'b1, 4, -1);
    @(negedge clock);
    check("abort_data_cleared", 32'(data), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    idle(2 * BIT);
    send_frame(9'h03C, 1'b1, 99, -1);
    idle(BIT);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-tick inverted glitch at mid-bit 3 must be voted out.
    send_frame(9'h0C3, 1'b1, 99, 3);
    idle(BIT);
`endif

    // Drain, bounded.
    for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
